// File: rtl/div_seq_unit.sv
// Sequential radix-2 non-restoring divider, signed or unsigned, one quotient bit per cycle.
// Divide-by-zero and signed overflow complete immediately without iterating.
module div_seq_unit #(
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          is_unsigned,
  input  logic          flush,
  input  logic [DW-1:0] dividend,
  input  logic [DW-1:0] divisor,
  output logic          busy,
  output logic          done,
  output logic [DW-1:0] quotient,
  output logic [DW-1:0] remainder,
  output logic          div_zero,
  output logic          overflow
);

  localparam int CW = $clog2(DW);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [DW-1:0] ONES     = {DW{1'b1}};
  localparam logic [DW-1:0] ZERO     = {DW{1'b0}};
  localparam logic [DW-1:0] MIN_NEG  = {1'b1, {(DW-1){1'b0}}};
  localparam logic [CW-1:0] CNT_LOAD = CW'(DW - 1);
  localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};

  function automatic logic [DW-1:0] neg2c(input logic [DW-1:0] v);
    return ~v + {{(DW-1){1'b0}}, 1'b1};
  endfunction

  function automatic logic [DW-1:0] mag(input logic [DW-1:0] v, input logic is_signed);
    return (is_signed && v[DW-1]) ? neg2c(v) : v;
  endfunction

  logic [1:0]    r_state;
  logic [CW-1:0] r_cnt;
  logic [DW-1:0] r_a;
  logic [DW-1:0] r_b;
  logic [DW:0]   r_p;
  logic          r_neg_q;
  logic          r_neg_r;
  logic          r_busy;
  logic          r_done;
  logic [DW-1:0] r_quot;
  logic [DW-1:0] r_rem;
  logic          r_dz;
  logic          r_ov;

  logic          w_signed;
  logic          w_accept;
  logic          w_dz;
  logic          w_ovf;
  logic [1:0]    w_next_state;
  logic [DW:0]   w_sh;
  logic [DW:0]   w_nx;
  logic [DW-1:0] w_rem_fix;
  logic [DW-1:0] w_q_fin;
  logic [DW-1:0] w_r_fin;

  assign w_signed = ~is_unsigned;
  assign w_accept = start && !flush && ((r_state == S_IDLE) || (r_state == S_DONE));
  assign w_dz     = (divisor == ZERO);
  assign w_ovf    = w_signed && (dividend == MIN_NEG) && (divisor == ONES);

  // Next-state selection; flush overrides everything including a new start.
  always_comb begin
    w_next_state = S_IDLE;
    if (flush) begin
      w_next_state = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (w_accept) begin
            w_next_state = (w_dz || w_ovf) ? S_DONE : S_CALC;
          end else begin
            w_next_state = S_IDLE;
          end
        end
        S_CALC: begin
          if (r_cnt == CNT_ZERO) begin
            w_next_state = S_FIX;
          end else begin
            w_next_state = S_CALC;
          end
        end
        S_FIX:   w_next_state = S_DONE;
        default: w_next_state = S_IDLE;
      endcase
    end
  end

  // One non-restoring step; arithmetic wraps at DW+1 bits since the true result always fits.
  always_comb begin
    w_sh = {r_p[DW-1:0], r_a[DW-1]};
    if (r_p[DW]) begin
      w_nx = w_sh + {1'b0, r_b};
    end else begin
      w_nx = w_sh - {1'b0, r_b};
    end
  end

  // Final correction and sign restoration applied in FIX.
  always_comb begin
    if (r_p[DW]) begin
      w_rem_fix = r_p[DW-1:0] + r_b;
    end else begin
      w_rem_fix = r_p[DW-1:0];
    end
    w_q_fin = r_neg_q ? neg2c(r_a) : r_a;
    w_r_fin = r_neg_r ? neg2c(w_rem_fix) : w_rem_fix;
  end

  // Control, iteration datapath and registered results.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= CNT_ZERO;
      r_a     <= ZERO;
      r_b     <= ZERO;
      r_p     <= {(DW+1){1'b0}};
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_quot  <= ZERO;
      r_rem   <= ZERO;
      r_dz    <= 1'b0;
      r_ov    <= 1'b0;
    end else begin
      r_state <= w_next_state;
      r_busy  <= (w_next_state == S_CALC) || (w_next_state == S_FIX);
      r_done  <= (w_next_state == S_DONE);
      if (w_accept) begin
        r_a     <= mag(dividend, w_signed);
        r_b     <= mag(divisor, w_signed);
        r_p     <= {(DW+1){1'b0}};
        r_cnt   <= CNT_LOAD;
        r_neg_q <= w_signed && (dividend[DW-1] ^ divisor[DW-1]);
        r_neg_r <= w_signed && dividend[DW-1];
        if (w_dz) begin
          r_quot <= ONES;
          r_rem  <= dividend;
          r_dz   <= 1'b1;
          r_ov   <= 1'b0;
        end else if (w_ovf) begin
          r_quot <= dividend;
          r_rem  <= ZERO;
          r_dz   <= 1'b0;
          r_ov   <= 1'b1;
        end
      end else if (!flush && (r_state == S_CALC)) begin
        r_p   <= w_nx;
        r_a   <= {r_a[DW-2:0], ~w_nx[DW]};
        r_cnt <= r_cnt - CNT_ONE;
      end else if (!flush && (r_state == S_FIX)) begin
        r_quot <= w_q_fin;
        r_rem  <= w_r_fin;
        r_dz   <= 1'b0;
        r_ov   <= 1'b0;
      end
    end
  end

  assign busy      = r_busy;
  assign done      = r_done;
  assign quotient  = r_quot;
  assign remainder = r_rem;
  assign div_zero  = r_dz;
  assign overflow  = r_ov;

endmodule

// File: doc/div_seq_unit.md
DIV_SEQ_UNIT -- requirements
Module: div_seq_unit

Interface
REQ-001 Parameter: DW, default 32, operand and result width; SHALL support any even DW >= 4.
REQ-002 The block SHALL have one clock; reset is synchronous and active-low.
REQ-003 clk  in  1  rising-edge clock for all state.
REQ-004 rst_n  in  1  synchronous active-low reset.
REQ-005 start  in  1  request; accepted only when busy=0.
REQ-006 is_unsigned  in  1  1 = unsigned divide, 0 = two's-complement signed; sampled with start.
REQ-007 flush  in  1  synchronous abort of the operation in flight.
REQ-008 dividend  in  DW  numerator; sampled with start.
REQ-009 divisor  in  DW  denominator; sampled with start.
REQ-010 busy  out  1  high in CALC and FIX states.
REQ-011 done  out  1  one-cycle pulse; results valid.
REQ-012 quotient  out  DW  registered quotient, held until the next done.
REQ-013 remainder  out  DW  registered remainder, held until the next done.
REQ-014 div_zero  out  1  divisor was zero; updated with done.
REQ-015 overflow  out  1  signed most-negative / -1 case; updated with done.

Function
REQ-016 States SHALL be IDLE, CALC, FIX and DONE; busy = (state==CALC || state==FIX).
REQ-017 IDLE/DONE with start=1 and flush=0: operands SHALL be latched, magnitudes taken (signed mode), iteration counter loaded with DW-1, and the next state SHALL be CALC.
REQ-018 DONE without an accepted start SHALL return to IDLE; DONE with an accepted start SHALL go directly to CALC, giving back-to-back operation.
REQ-019 CALC: one radix-2 non-restoring step per cycle on a DW+1-bit partial remainder, one quotient bit per cycle, DW cycles total; counter 0 -> FIX.
REQ-020 FIX: one cycle. Negative partial remainder SHALL be corrected by adding the divisor magnitude. Signed mode: the quotient SHALL be negated iff the operand signs differ, and the remainder SHALL take the dividend's sign. Next state SHALL be DONE.
REQ-021 On the edge entering DONE, quotient, remainder, div_zero and overflow SHALL be registered, and done SHALL be 1 for exactly that one cycle.
REQ-022 Latency: start high in cycle 0 -> done high in cycle DW+2 (cycle 34 for DW=32).
REQ-023 Divide-by-zero fast path: divisor==0 at start SHALL go IDLE -> DONE, done in cycle 1, quotient = all ones, remainder = dividend, div_zero = 1, for both signed and unsigned.
REQ-024 Overflow fast path: is_unsigned=0, dividend = 1 followed by DW-1 zeros, divisor = all ones SHALL go IDLE -> DONE, done in cycle 1, quotient = dividend, remainder = 0, overflow = 1.
REQ-025 div_zero and overflow SHALL be 0 on every normal completion.
REQ-026 start while busy=1 SHALL be ignored without any state change.
REQ-027 flush=1 SHALL force IDLE on the next edge with no done; flush SHALL take priority over start in the same cycle; result outputs SHALL keep their prior values.
REQ-028 Operand inputs SHALL be don't-care outside the start-acceptance cycle.

Reset
REQ-029 rst_n=0 at a rising edge SHALL force state IDLE and clear busy, done, quotient, remainder, div_zero and overflow to 0, regardless of any operation in flight.
REQ-030 After reset, no done SHALL be produced until a new start is accepted.

Verification
REQ-031 DW=32, signed, -11 / 3 -> cycle 34: done=1, quotient=0xFFFFFFFD, remainder=0xFFFFFFFE; unsigned, 0xFFFFFFF5 / 3 -> quotient=0x55555551, remainder=2.
REQ-032 Back-to-back: 10/5, then start in the DONE cycle with 128/13 -> results 2 r 0, then 9 r 11, each DW+2 cycles after its start.
REQ-033 7 / 0 (signed and unsigned) -> done in cycle 1, quotient=0xFFFFFFFF, remainder=7, div_zero=1; signed 0x80000000 / 0xFFFFFFFF -> quotient=0x80000000, remainder=0, overflow=1.
REQ-034 flush at cycle 10 of a run -> IDLE next cycle, busy=0, no done, outputs unchanged; start during busy -> ignored, and the first result still matches.
REQ-035 rst_n=0 at cycle 15 of a run -> all outputs 0, state IDLE, no later spurious done.
REQ-036 DW=8 instance: signed -128 / -1 -> overflow=1, quotient=0x80; unsigned 200 / 7 -> quotient=28, remainder=4, done in cycle 10.
